// File: rtl/spi_sram_responder.sv
// SPI SRAM target answering the 23K640 command set (WRSR/WRITE/READ/RDSR)
// over an oversampled SPI link, backed by a 2^ADDR_W byte array.
module spi_sram_responder #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned PAGE_W = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_sck,
  input  logic              i_cs,
  input  logic              i_si,
  output logic              o_so,
  output logic [7:0]        o_status,
  output logic              o_busy,
  output logic              o_wr_stb,
  output logic [ADDR_W-1:0] o_wr_addr
);

  localparam logic [7:0] CMD_WRSR  = 8'h01;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_RDSR  = 8'h05;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_RD_DATA,
    S_WR_DATA,
    S_WRSR,
    S_RDSR,
    S_IGNORE
  } state_t;

  // Input synchronisers; CS idles high so its flops reset to 1.
  logic [1:0] sck_sync;
  logic [1:0] cs_sync;
  logic [1:0] si_sync;
  logic       sck_prev;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sck_sync <= '0;
      cs_sync  <= '1;
      si_sync  <= '0;
      sck_prev <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[0], i_sck};
      cs_sync  <= {cs_sync[0], i_cs};
      si_sync  <= {si_sync[0], i_si};
      sck_prev <= sck_sync[1];
    end
  end

  logic sck_s;
  logic cs_s;
  logic si_s;
  logic sck_rise;
  logic sck_fall;

  assign sck_s    = sck_sync[1];
  assign cs_s     = cs_sync[1];
  assign si_s     = si_sync[1];
  assign sck_rise = sck_s & ~sck_prev;
  assign sck_fall = ~sck_s & sck_prev;

  state_t              state;
  logic                is_read;
  logic [3:0]          bit_cnt;
  logic [6:0]          sh_in;
  logic [7:0]          sh_out;
  logic [ADDR_W-1:0]   addr;
  logic [7:0]          status;

  logic [7:0] mem [0:(1 << ADDR_W) - 1];

  logic [7:0]        byte_nx;
  logic [ADDR_W-1:0] addr_sh_nx;
  logic [ADDR_W-1:0] addr_adv;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              byte_done;
  logic              seq_mode;
  logic              page_mode;
  logic              burst_mode;
  logic              mem_we;

  assign byte_nx    = {sh_in, si_s};
  // The address is shifted straight into addr; only the low ADDR_W of the
  // 16 inbound bits survive, which drops the unimplemented upper bits.
  assign addr_sh_nx = {addr[ADDR_W-2:0], si_s};
  assign byte_done  = (bit_cnt == 4'd7);
  assign seq_mode   = (status[7:6] == 2'b01);
  assign page_mode  = (status[7:6] == 2'b10);
  assign burst_mode = seq_mode | page_mode;

  always_comb begin
    addr_adv = addr;
    if (seq_mode) begin
      addr_adv = addr + ADDR_W'(1);
    end else if (page_mode) begin
      addr_adv[PAGE_W-1:0] = addr[PAGE_W-1:0] + PAGE_W'(1);
    end
  end

  assign rd_addr = (state == S_ADDR) ? addr_sh_nx : addr_adv;
  assign rd_data = mem[rd_addr];
  assign mem_we  = ~cs_s & sck_rise & (state == S_WR_DATA) & byte_done;

  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      mem[addr] <= byte_nx;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= S_IDLE;
      is_read   <= 1'b0;
      bit_cnt   <= '0;
      sh_in     <= '0;
      sh_out    <= '0;
      addr      <= '0;
      status    <= '0;
      o_so      <= 1'b0;
      o_busy    <= 1'b0;
      o_wr_stb  <= 1'b0;
      o_wr_addr <= '0;
    end else begin
      o_wr_stb <= 1'b0;
      o_busy   <= ~cs_s;
      // CS high overrides everything, including an SCK rise seen in the
      // same synchronised cycle, so a partial byte can never commit.
      if (cs_s) begin
        state   <= S_IDLE;
        bit_cnt <= '0;
        o_so    <= 1'b0;
      end else if (state == S_IDLE) begin
        state   <= S_CMD;
        bit_cnt <= '0;
      end else begin
        if (sck_fall) begin
          if (state == S_RD_DATA || state == S_RDSR) begin
            o_so   <= sh_out[7];
            sh_out <= {sh_out[6:0], 1'b0};
          end else begin
            o_so <= 1'b0;
          end
        end

        if (sck_rise) begin
          sh_in   <= byte_nx[6:0];
          bit_cnt <= bit_cnt + 4'd1;
          case (state)
            S_CMD: begin
              if (byte_done) begin
                bit_cnt <= '0;
                case (byte_nx)
                  CMD_WRITE: begin
                    is_read <= 1'b0;
                    state   <= S_ADDR;
                  end
                  CMD_READ: begin
                    is_read <= 1'b1;
                    state   <= S_ADDR;
                  end
                  CMD_WRSR: state <= S_WRSR;
                  CMD_RDSR: begin
                    sh_out <= status;
                    state  <= S_RDSR;
                  end
                  default: state <= S_IGNORE;
                endcase
              end
            end
            S_ADDR: begin
              addr <= addr_sh_nx;
              if (bit_cnt == 4'd15) begin
                bit_cnt <= '0;
                if (is_read) begin
                  sh_out <= rd_data;
                  state  <= S_RD_DATA;
                end else begin
                  state <= S_WR_DATA;
                end
              end
            end
            S_RD_DATA: begin
              if (byte_done) begin
                bit_cnt <= '0;
                if (burst_mode) begin
                  addr   <= addr_adv;
                  sh_out <= rd_data;
                end else begin
                  state <= S_IGNORE;
                end
              end
            end
            S_WR_DATA: begin
              if (byte_done) begin
                bit_cnt   <= '0;
                o_wr_stb  <= 1'b1;
                o_wr_addr <= addr;
                if (burst_mode) begin
                  addr <= addr_adv;
                end else begin
                  state <= S_IGNORE;
                end
              end
            end
            S_WRSR: begin
              if (byte_done) begin
                bit_cnt <= '0;
                status  <= byte_nx;
                state   <= S_IGNORE;
              end
            end
            S_RDSR: begin
              if (byte_done) begin
                bit_cnt <= '0;
                sh_out  <= status;
              end
            end
            default: bit_cnt <= '0;
          endcase
        end
      end
    end
  end

  assign o_status = status;

endmodule

// File: tb/tb_spi_sram_responder.sv
// Scoreboard bench for spi_sram_responder: an SPI controller model drives
// random and directed transactions against a behavioural memory model.
module tb_spi_sram_responder;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned PAGE_W = 5;
  localparam int DEPTH = 1 << ADDR_W;
  localparam int PAGE  = 1 << PAGE_W;
  localparam int HALF  = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              sck;
  logic              cs;
  logic              si;
  logic              so;
  logic [7:0]        status;
  logic              busy;
  logic              wr_stb;
  logic [ADDR_W-1:0] wr_addr;

  always #5 clk = ~clk;

  spi_sram_responder #(
    .ADDR_W(ADDR_W),
    .PAGE_W(PAGE_W)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_sck    (sck),
    .i_cs     (cs),
    .i_si     (si),
    .o_so     (so),
    .o_status (status),
    .o_busy   (busy),
    .o_wr_stb (wr_stb),
    .o_wr_addr(wr_addr)
  );

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [7:0] v;
    bit         known;
  } exp_rd_t;

  exp_rd_t    exp_rd_q[$];
  logic [7:0] got_q[$];
  int         exp_wr_q[$];
  logic [7:0] wbuf[$];

  logic [7:0] ref_mem [DEPTH];
  bit         ref_known [DEPTH];
  logic [7:0] ref_status = 8'h00;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Returns -1 once the mode allows no further data bytes.
  function automatic int next_addr(int a);
    case (ref_status[7:6])
      2'b01:   return (a + 1) % DEPTH;
      2'b10:   return (a / PAGE) * PAGE + ((a + 1) % PAGE);
      default: return -1;
    endcase
  endfunction

  // Monitor: write strobes and completed read bytes against the queues.
  always @(negedge clk) begin
    exp_rd_t    e;
    logic [7:0] g;
    if (wr_stb) begin
      if (exp_wr_q.size() == 0) check("unexpected_wr_stb", 32'(wr_stb), 32'd0);
      else check("wr_addr", 32'(wr_addr), 32'(exp_wr_q.pop_front()));
    end
    if (got_q.size() != 0) begin
      g = got_q.pop_front();
      if (exp_rd_q.size() == 0) begin
        check("rd_expect_depth", 32'(exp_rd_q.size()), 32'd1);
      end else begin
        e = exp_rd_q.pop_front();
        if (e.known) check("rd_byte", 32'(g), 32'(e.v));
      end
    end
  end

  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      si = tx[i];
      repeat (HALF) @(negedge clk);
      rx  = {rx[6:0], so};
      sck = 1'b1;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, input bit capture);
    logic [7:0] rx;
    spi_bits(tx, 8, rx);
    if (capture) got_q.push_back(rx);
  endtask

  task automatic cs_low();
    @(negedge clk);
    cs = 1'b0;
    repeat (HALF) @(negedge clk);
    check("busy_in_txn", 32'(busy), 32'd1);
  endtask

  task automatic cs_high();
    repeat (HALF) @(negedge clk);
    cs = 1'b1;
    repeat (3 * HALF) @(negedge clk);
  endtask

  task automatic send_addr(input logic [7:0] cmd, input logic [15:0] addr);
    spi_byte(cmd, 1'b0);
    spi_byte(addr[15:8], 1'b0);
    spi_byte(addr[7:0], 1'b0);
  endtask

  task automatic do_wrsr(input logic [7:0] v);
    ref_status = v;
    cs_low();
    spi_byte(8'h01, 1'b0);
    spi_byte(v, 1'b0);
    cs_high();
    check("status_after_wrsr", 32'(status), 32'(ref_status));
  endtask

  task automatic do_rdsr(input int n);
    exp_rd_t e;
    for (int i = 0; i < n; i++) begin
      e.v = ref_status;
      e.known = 1'b1;
      exp_rd_q.push_back(e);
    end
    cs_low();
    spi_byte(8'h05, 1'b0);
    for (int i = 0; i < n; i++) spi_byte(8'h00, 1'b1);
    cs_high();
  endtask

  task automatic do_write(input logic [15:0] addr);
    int a;
    a = int'(addr) % DEPTH;
    foreach (wbuf[i]) begin
      if (a >= 0) begin
        exp_wr_q.push_back(a);
        ref_mem[a]   = wbuf[i];
        ref_known[a] = 1'b1;
        a = next_addr(a);
      end
    end
    cs_low();
    send_addr(8'h02, addr);
    foreach (wbuf[i]) spi_byte(wbuf[i], 1'b0);
    cs_high();
  endtask

  task automatic do_read(input logic [15:0] addr, input int n);
    int      a;
    exp_rd_t e;
    a = int'(addr) % DEPTH;
    for (int i = 0; i < n; i++) begin
      if (a < 0) begin
        e.v = 8'h00;
        e.known = 1'b1;
      end else begin
        e.v = ref_mem[a];
        e.known = ref_known[a];
        a = next_addr(a);
      end
      exp_rd_q.push_back(e);
    end
    cs_low();
    send_addr(8'h03, addr);
    for (int i = 0; i < n; i++) spi_byte(8'h00, 1'b1);
    cs_high();
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rx;
    exp_rd_t    e;
    rst = 1'b1;
    sck = 1'b0;
    cs  = 1'b1;
    si  = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_so", 32'(so), 32'd0);
    check("rst_status", 32'(status), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr_stb", 32'(wr_stb), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Configure and read back status
    do_wrsr(8'h41);
    do_rdsr(2);

    // Byte mode single write/read, extra bytes dropped / read as zero
    do_wrsr(8'h00);
    wbuf.delete(); wbuf.push_back(8'hA5); wbuf.push_back(8'h3C);
    do_write(16'h0123);
    do_read(16'h0123, 2);

    // Sequential burst across the top of the array
    do_wrsr(8'h41);
    wbuf.delete(); wbuf.push_back(8'h11); wbuf.push_back(8'h22); wbuf.push_back(8'h33);
    do_write(16'h03FE);
    do_read(16'h03FE, 3);
    wbuf.delete(); wbuf.push_back(8'h77);
    do_write(16'h0020);

    // Page wrap leaves the next page untouched
    do_wrsr(8'h80);
    wbuf.delete(); wbuf.push_back(8'hAA); wbuf.push_back(8'hBB);
    do_write(16'h001F);
    do_read(16'h0020, 1);
    do_read(16'h001F, 2);

    // Abort after 5 data bits: nothing commits
    do_wrsr(8'h00);
    wbuf.delete(); wbuf.push_back(8'h5A);
    do_write(16'h0010);
    cs_low();
    send_addr(8'h02, 16'h0010);
    spi_bits(8'hFF, 5, rx);
    cs_high();
    do_read(16'h0010, 1);

    // CS rise coincident with the 8th SCK rise: CS wins
    wbuf.delete(); wbuf.push_back(8'h6B);
    do_write(16'h0011);
    cs_low();
    send_addr(8'h02, 16'h0011);
    spi_bits(8'hF0, 7, rx);
    si = 1'b1;
    repeat (HALF) @(negedge clk);
    sck = 1'b1;
    cs  = 1'b1;
    repeat (HALF) @(negedge clk);
    sck = 1'b0;
    repeat (3 * HALF) @(negedge clk);
    do_read(16'h0011, 1);

    // Unknown command: SO held low, no side effects
    for (int i = 0; i < 2; i++) begin
      e.v = 8'h00;
      e.known = 1'b1;
      exp_rd_q.push_back(e);
    end
    cs_low();
    spi_byte(8'h9F, 1'b0);
    spi_byte(8'hFF, 1'b1);
    spi_byte(8'hFF, 1'b1);
    cs_high();
    check("status_after_unknown", 32'(status), 32'(ref_status));

    // Randomised transactions across all modes
    for (int t = 0; t < 16; t++) begin
      logic [1:0]  mode;
      logic [15:0] a;
      int          n;
      mode = 2'($urandom_range(0, 3));
      do_wrsr({mode, 6'($urandom_range(0, 63))});
      a = 16'($urandom);
      n = $urandom_range(1, 4);
      if ($urandom_range(0, 1) == 0) begin
        wbuf.delete();
        for (int i = 0; i < n; i++) wbuf.push_back(8'($urandom));
        do_write(a);
        do_wrsr(8'h41);
        do_read(a, n);
      end else begin
        do_read(a, n);
      end
    end

    // Reset in the middle of a read
    do_wrsr(8'h41);
    cs_low();
    send_addr(8'h03, 16'h0123);
    spi_bits(8'h00, 3, rx);
    #2 rst = 1'b1;
    #1;
    check("midrst_so", 32'(so), 32'd0);
    check("midrst_status", 32'(status), 32'h00);
    check("midrst_busy", 32'(busy), 32'd0);
    cs  = 1'b1;
    sck = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    ref_status = 8'h00;
    repeat (10) @(negedge clk);
    do_read(16'h0123, 1);
    do_rdsr(1);

    repeat (20) @(negedge clk);
    check("pending_wr_strobes", 32'(exp_wr_q.size()), 32'd0);
    check("pending_rd_bytes", 32'(exp_rd_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
